fp_addsub_pipe: RTL
===================

# fp_addsub_pipe

Parametrised, pipelined IEEE-754-style floating-point adder/subtractor. It is the clocked successor to the single-precision combinational adder: exponent and mantissa widths are generic, a per-operation add/subtract mode is provided, and results round to nearest-even. It also handles special values, raises exception flags, and uses a valid/ready stream handshake with full backpressure. It sits between operand-fetch and writeback in the FP datapath and accepts one operation per cycle.

## Interface
- `EXP_W`, 8: exponent field width (≥3).
- `MAN_W`, 23: stored mantissa field width, without the hidden bit (≥4).
- Word width `W = 1 + EXP_W + MAN_W` is derived, not a parameter.
- `clk` input 1: single clock. All state is updated on the rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `in_valid` input 1: the operand set on `a`/`b`/`sub` is valid.
- `in_ready` output 1: the block accepts the operand set this cycle.
- `a` input W: operand A, packed as {sign, exp, man}.
- `b` input W: operand B.
- `sub` input 1: 0 computes a+b; 1 computes a−b (flips the sign of b).
- `out_valid` output 1: `result`/`flags` hold a valid result.
- `out_ready` input 1: the consumer accepts the result this cycle.
- `result` output W: the packed sum or difference.
- `flags` output 3: {invalid, overflow, underflow}, aligned with `result`.

## Operation
- Four pipeline stages, each with its own valid bit.
  - S1, unpack: apply `sub`; classify each operand as zero, normal, inf or NaN; swap so that |A| ≥ |B| (compare exponent, then mantissa).
  - S2, align: right-shift the smaller mantissa by the exponent difference. Shift amount saturates at MAN_W+3. Every bit shifted out ORs into sticky.
  - S3, add/sub: add when signs are equal, otherwise subtract. Datapath is MAN_W+5 bits: carry, hidden bit, mantissa, guard, round, sticky. Result sign is the sign of the larger operand.
  - S4, normalise and round:
    - On carry-out, shift right 1 and increment exponent.
    - Otherwise, leading-zero count, left shift, and decrement exponent.
    - Round to nearest-even using guard/round/sticky. A mantissa overflow from rounding increments the exponent.
    - Pack the result and set flags.
- Denormals are flushed to zero:
  - An input with exp==0 is treated as ±0.
  - If the normalised exponent is ≤0, the result is signed zero and underflow=1.
- Overflow: if the final exponent is ≥ 2^EXP_W−1, the result is ±inf and overflow=1.
- Special values:
  - Any NaN input gives canonical qNaN: sign 0, exp all-ones, man MSB 1, rest 0.
  - inf + (−inf) after applying `sub` gives qNaN with invalid=1.
  - inf ± finite gives that inf.
- Zeros:
  - Exact cancellation of nonzero operands gives +0.
  - (−0)+(−0) gives −0; otherwise a ±0 operand returns the other operand unchanged.
- `flags` is all-zero unless set by one of the rules above.

## Timing
- Latency is 4 cycles from acceptance (in_valid & in_ready) to out_valid, with no stall.
- Throughput is 1 op/cycle.
- Pipeline enable `adv = !out_valid | out_ready`.
  - All stages shift together when adv=1.
  - `in_ready = adv`, which is combinational from out_ready.
- While out_valid=1 and out_ready=0:
  - result, flags and out_valid hold stable.
  - in_ready=0, and no stage changes.
- An empty stage is a bubble and advances as normal. Results leave in acceptance order, with no loss or duplication.
- A result is consumed on a cycle with out_valid & out_ready.
- in_valid=0 while in_ready=1 inserts a bubble.
- Reset, including mid-operation, clears all stage valid bits immediately. Reset values:
  - in_ready=1 (combinational after reset).
  - out_valid=0, result=0, flags=0.
- Data registers may hold stale values while their valid bit is 0. Only the output register is reset to 0.

## Test plan
- **Basic add/sub:** with defaults, send 0x3F800000 + 0x3F800000, then 0x3FC00000 with sub=1 against 0x3F000000, out_ready=1.
  - Required: 0x40000000 appears exactly 4 cycles after acceptance, then 0x3F800000 on the next cycle; flags=000.
- **Rounding:** send 0x3F800000 + 0x33800000 (tie) and 0x3F800000 + 0x33C00000.
  - Required: 0x3F800000 and 0x3F800001 respectively.
- **Cancellation and zeros:** send 0xC618CAAE + 0x4618CAAE, then 0x80000000 + 0x80000000.
  - Required: 0x00000000, then 0x80000000.
- **Exceptions:**
  - 0x7F7FFFFF + 0x7F7FFFFF → 0x7F800000, flags=010.
  - 0x7F800000 with sub=1 against 0x7F800000 → 0x7FC00000, flags=100.
  - 0x00000001 + 0x00000000 → 0x00000000 (denormal flushed).
  - 0x00800000 with sub=1 against 0x00C00000 → 0x80000000, flags=001.
- **Backpressure:** stream 8 distinct operations back-to-back; drop out_ready for 3 cycles once out_valid rises.
  - Required: in_ready=0 during the stall, result held stable, all 8 results in order, no duplicates.
- **Reset:** assert rst asynchronously while 3 ops are in flight; release and send 0x3F800000 + 0x3F800000.
  - Required: out_valid=0 and result=0 immediately on rst; only 0x40000000 appears afterwards, 4 cycles after acceptance.
- **Non-default widths:** repeat the basic add/sub case with EXP_W=5, MAN_W=10.
  - Required: 0x3C00 + 0x3C00 → 0x4000.

Source files
------------

// File: rtl/fp_addsub_pipe.sv
// -----------------------------------------------------------------------------
// fp_addsub_pipe
// Pipelined floating-point adder/subtractor with parametrised exponent and
// mantissa widths. It rounds to nearest-even, flushes denormals to zero and
// handles NaN, infinity and signed zero. A valid/ready stream handshake with
// full backpressure is used on both sides, and the block sustains one operation
// per cycle.
//
// Stages:
//   S1 unpack    : apply sub, classify, resolve special cases, order by magnitude
//   S2 align     : right-shift the smaller mantissa, collect sticky
//   S3 add/sub   : magnitude add or subtract
//   S4 normalise : normalise, round, pack, raise flags (output register)
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   in_valid, in_ready  input handshake; in_ready = !out_valid | out_ready
//   a, b                operands packed {sign, exp, man}
//   sub                 1: compute a - b, 0: compute a + b
//   out_valid,out_ready output handshake
//   result              packed sum or difference
//   flags               {invalid, overflow, underflow}
// -----------------------------------------------------------------------------
module fp_addsub_pipe #(
  parameter  int EXP_W = 8,
  parameter  int MAN_W = 23,
  localparam int W     = 1 + EXP_W + MAN_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         sub,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] result,
  output logic [2:0]   flags
);

  // Extended datapath: carry, hidden, mantissa, guard, round, sticky.
  localparam int NW     = MAN_W + 5;
  localparam int SH_MAX = MAN_W + 3;
  localparam int SH_W   = $clog2(MAN_W + 4);
  localparam int LZ_W   = $clog2(NW);
  // Signed exponent width wide enough for +2 carry headroom and the largest
  // normalisation left shift.
  localparam int XW     = ((EXP_W > LZ_W) ? EXP_W : LZ_W) + 2;

  localparam logic [W-1:0] QNAN =
    {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
  localparam logic signed [XW-1:0] ONE     = XW'(1);
  localparam logic signed [XW-1:0] EXP_MAX = XW'((1 << EXP_W) - 1);

  // Whole pipeline moves together; it only stops when the output is blocked.
  logic adv;
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  // ---------------------------------------------------------------------------
  // S1: unpack and classify
  // ---------------------------------------------------------------------------
  logic             sign_a, sign_b;
  logic [EXP_W-1:0] exp_a, exp_b;
  logic [MAN_W-1:0] man_a, man_b;
  logic             nan_a, nan_b, inf_a, inf_b, zero_a, zero_b, swap;
  logic             spec0;
  logic [W-1:0]     spec_res0;
  logic [2:0]       spec_flags0;

  assign sign_a = a[W-1];
  assign sign_b = b[W-1] ^ sub;
  assign exp_a  = a[W-2:MAN_W];
  assign exp_b  = b[W-2:MAN_W];
  assign man_a  = a[MAN_W-1:0];
  assign man_b  = b[MAN_W-1:0];
  assign nan_a  = (&exp_a) && (|man_a);
  assign nan_b  = (&exp_b) && (|man_b);
  assign inf_a  = (&exp_a) && !(|man_a);
  assign inf_b  = (&exp_b) && !(|man_b);
  // Denormals are flushed: any exp==0 operand counts as zero.
  assign zero_a = !(|exp_a);
  assign zero_b = !(|exp_b);
  // {exp, man} compares as an unsigned magnitude.
  assign swap   = b[W-2:0] > a[W-2:0];

  // Every case except "two finite nonzero operands" is fully resolved here and
  // carried alongside the arithmetic stages.
  // NOTE: every variable written in a combinational block gets a default at the
  // top, so no path can leave it unassigned and infer a latch.
  always_comb begin
    spec0       = 1'b1;
    spec_res0   = '0;
    spec_flags0 = '0;
    if (nan_a || nan_b) begin
      spec_res0 = QNAN;
    end else if (inf_a && inf_b && (sign_a != sign_b)) begin
      spec_res0   = QNAN;
      spec_flags0 = 3'b100;
    end else if (inf_a) begin
      spec_res0 = a;
    end else if (inf_b) begin
      spec_res0 = {sign_b, b[W-2:0]};
    end else if (zero_a && zero_b) begin
      spec_res0 = {sign_a & sign_b, {(W-1){1'b0}}};
    end else if (zero_a) begin
      spec_res0 = {sign_b, b[W-2:0]};
    end else if (zero_b) begin
      spec_res0 = a;
    end else begin
      spec0 = 1'b0;
    end
  end

  logic             v1, v2, v3;
  logic             s1_sign, s1_eff_sub, s1_spec;
  logic [EXP_W-1:0] s1_exp_big, s1_exp_small;
  logic [MAN_W-1:0] s1_man_big, s1_man_small;
  logic [W-1:0]     s1_spec_res;
  logic [2:0]       s1_spec_flags;

  // ---------------------------------------------------------------------------
  // S2: align
  // ---------------------------------------------------------------------------
  logic [EXP_W-1:0] exp_diff;
  logic [SH_W-1:0]  sh_amt;
  logic [NW-1:0]    big_ext, small_ext, small_shr, shr_mask, small_aln;

  assign exp_diff  = s1_exp_big - s1_exp_small;
  assign sh_amt    = (int'(exp_diff) > SH_MAX) ? SH_W'(SH_MAX) : SH_W'(exp_diff);
  assign big_ext   = {1'b0, 1'b1, s1_man_big, 3'b000};
  assign small_ext = {1'b0, 1'b1, s1_man_small, 3'b000};
  assign small_shr = small_ext >> sh_amt;
  assign shr_mask  = ~({NW{1'b1}} << sh_amt);
  // Any bit shifted out lands in the sticky position.
  assign small_aln = small_shr | NW'(|(small_ext & shr_mask));

  logic             s2_sign, s2_eff_sub, s2_spec;
  logic [EXP_W-1:0] s2_exp;
  logic [NW-1:0]    s2_big, s2_small;
  logic [W-1:0]     s2_spec_res;
  logic [2:0]       s2_spec_flags;

  // ---------------------------------------------------------------------------
  // S3: magnitude add/subtract (|big| >= |small| so no negative result)
  // ---------------------------------------------------------------------------
  logic [NW-1:0] sum3;
  assign sum3 = s2_eff_sub ? (s2_big - s2_small) : (s2_big + s2_small);

  logic             s3_sign, s3_spec;
  logic [EXP_W-1:0] s3_exp;
  logic [NW-1:0]    s3_sum;
  logic [W-1:0]     s3_spec_res;
  logic [2:0]       s3_spec_flags;

  // ---------------------------------------------------------------------------
  // S4: normalise, round, pack
  // ---------------------------------------------------------------------------
  logic [NW-2:0]          n_raw, norm;
  logic [LZ_W-1:0]        lz;
  logic signed [XW-1:0]   exp_b4, exp_n, exp_f;
  logic                   round_up;
  logic [MAN_W+1:0]       rnd;
  logic [MAN_W-1:0]       man_f;
  logic [W-1:0]           res4;
  logic [2:0]             flags4;

  always_comb begin
    n_raw = s3_sum[NW-2:0];
    // Ascending scan: the highest set bit is written last and wins.
    lz = '0;
    for (int i = 0; i < NW-1; i++) begin
      if (n_raw[i]) lz = LZ_W'(NW - 2 - i);
    end
    exp_b4 = $signed({{(XW-EXP_W){1'b0}}, s3_exp});
    if (s3_sum[NW-1]) begin
      // Carry out: keep the dropped bit in sticky.
      norm  = {s3_sum[NW-1:2], s3_sum[1] | s3_sum[0]};
      exp_n = exp_b4 + ONE;
    end else begin
      norm  = n_raw << lz;
      exp_n = exp_b4 - $signed({{(XW-LZ_W){1'b0}}, lz});
    end
    // Nearest-even: guard set and (round | sticky | lsb).
    round_up = norm[2] & (norm[1] | norm[0] | norm[3]);
    rnd      = {1'b0, norm[NW-2:3]} + {{(MAN_W+1){1'b0}}, round_up};
    if (rnd[MAN_W+1]) begin
      exp_f = exp_n + ONE;
      man_f = rnd[MAN_W:1];
    end else begin
      exp_f = exp_n;
      man_f = rnd[MAN_W-1:0];
    end

    res4   = {s3_sign, exp_f[EXP_W-1:0], man_f};
    flags4 = '0;
    if (s3_spec) begin
      res4   = s3_spec_res;
      flags4 = s3_spec_flags;
    end else if (s3_sum == '0) begin
      res4 = '0;                                   // exact cancellation is +0
    end else if (exp_n[XW-1] || (exp_n == '0)) begin
      res4   = {s3_sign, {(W-1){1'b0}}};
      flags4 = 3'b001;
    end else if (exp_f >= EXP_MAX) begin
      res4   = {s3_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      flags4 = 3'b010;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage data registers
  // ---------------------------------------------------------------------------
  // NOTE: pipeline data registers carry no reset; their contents are ignored
  // while the matching valid bit is low, so only valids and outputs reset.
  always_ff @(posedge clk) begin
    if (adv) begin
      s1_sign       <= swap ? sign_b : sign_a;
      s1_eff_sub    <= sign_a ^ sign_b;
      s1_exp_big    <= swap ? exp_b : exp_a;
      s1_exp_small  <= swap ? exp_a : exp_b;
      s1_man_big    <= swap ? man_b : man_a;
      s1_man_small  <= swap ? man_a : man_b;
      s1_spec       <= spec0;
      s1_spec_res   <= spec_res0;
      s1_spec_flags <= spec_flags0;

      s2_sign       <= s1_sign;
      s2_eff_sub    <= s1_eff_sub;
      s2_exp        <= s1_exp_big;
      s2_big        <= big_ext;
      s2_small      <= small_aln;
      s2_spec       <= s1_spec;
      s2_spec_res   <= s1_spec_res;
      s2_spec_flags <= s1_spec_flags;

      s3_sign       <= s2_sign;
      s3_exp        <= s2_exp;
      s3_sum        <= sum3;
      s3_spec       <= s2_spec;
      s3_spec_res   <= s2_spec_res;
      s3_spec_flags <= s2_spec_flags;
    end
  end

  // Valid bits and the output register.
  // NOTE: sequential state is assigned with <= so every register samples the
  // pre-edge value of its neighbours regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1        <= 1'b0;
      v2        <= 1'b0;
      v3        <= 1'b0;
      out_valid <= 1'b0;
      result    <= '0;
      flags     <= '0;
    end else if (adv) begin
      v1        <= in_valid;
      v2        <= v1;
      v3        <= v2;
      out_valid <= v3;
      if (v3) begin
        result <= res4;
        flags  <= flags4;
      end
    end
  end

endmodule
